// File: rtl/video_scandoubler_pkg.sv
// Shared video constants for the scandoubler and the output palette stage.
// Latency: n/a (constants only).
// Backpressure: n/a.
package video_scandoubler_pkg;

    // Pixel slots per line bank and the matching pointer width.
    localparam int SD_LINE_LEN = 512;
    localparam int SD_ADDR_W   = 9;

    // The bank select occupies the address bit just above the line pointer.
    localparam int SD_BANK_BIT = SD_ADDR_W;

endpackage

// File: rtl/video_scandoubler_dpram.sv
// Simple dual-port RAM: port A writes, port B reads.
// Latency: port B read data registered, 1 clk after the address.
// Backpressure: none; both ports accept every clk.
module video_scandoubler_dpram #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 10
) (
    input  logic                 i_clk,
    input  logic                 i_we_a,
    input  logic [ADDRWIDTH-1:0] i_addr_a,
    input  logic [DATAWIDTH-1:0] i_dat_a,
    input  logic [ADDRWIDTH-1:0] i_addr_b,
    output logic [DATAWIDTH-1:0] o_dat_b
);

    logic [DATAWIDTH-1:0] r_mem [0:(2**ADDRWIDTH)-1];
    logic [DATAWIDTH-1:0] r_dat_b;

    // Port A write.
    always_ff @(posedge i_clk) begin
        if (i_we_a) begin
            r_mem[i_addr_a] <= i_dat_a;
        end
    end

    // Port B registered read; old data is returned on a same-address write.
    always_ff @(posedge i_clk) begin
        r_dat_b <= r_mem[i_addr_b];
    end

    assign o_dat_b = r_dat_b;

endmodule

// File: rtl/video_scandoubler.sv
// Line-doubling buffer: TV-rate pixels into one bank, VGA-rate reads from the other.
// Latency: vgaplex valid 2 clk after the rd_stb cycle (RAM read + output register).
// Backpressure: none; strobes are always accepted, pointers saturate at the line end.
module video_scandoubler
    import video_scandoubler_pkg::*;
#(
    parameter int LINE_LEN = SD_LINE_LEN,
    parameter int ADDR_W   = SD_ADDR_W
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_wr_stb,
    input  logic [7:0] i_vplex_in,
    input  logic       i_tv_active,
    input  logic       i_tv_line_start,
    input  logic       i_rd_stb,
    input  logic       i_vga_active,
    input  logic       i_vga_line_start,
    input  logic       i_frame_start,
    output logic [7:0] o_vgaplex,
    output logic       o_vga_line
);

    localparam logic [ADDR_W-1:0] PTR_MAX = ADDR_W'(LINE_LEN - 1);

    logic              r_wbank;
    logic [ADDR_W-1:0] r_wptr;
    logic              r_rbank;
    logic [ADDR_W-1:0] r_rptr;
    logic              r_vga_line;
    logic [7:0]        r_vgaplex;
    logic              r_p1_rd;     // RAM output holds a qualified read this clk
    logic              r_p1_blank;  // a read outside the visible window is in flight

    logic              w_wr_en;
    logic              w_rd_go;
    logic              w_rd_blank;
    logic [ADDR_W:0]   w_wr_addr;
    logic [ADDR_W:0]   w_rd_addr;
    logic [7:0]        w_ram_q;

    // A line start owns its cycle: coincident strobes are dropped.
    assign w_wr_en    = i_rst_n & i_wr_stb & i_tv_active & ~i_tv_line_start;
    assign w_rd_go    = i_rd_stb & i_vga_active & ~i_vga_line_start;
    assign w_rd_blank = i_rd_stb & ~i_vga_active & ~i_vga_line_start;

    // Bank bit is the address MSB (SD_BANK_BIT), pointer below it.
    assign w_wr_addr = {r_wbank, r_wptr};
    assign w_rd_addr = {r_rbank, r_rptr};

    video_scandoubler_dpram #(
        .DATAWIDTH (8),
        .ADDRWIDTH (ADDR_W + 1)
    ) u_dpram (
        .i_clk    (i_clk),
        .i_we_a   (w_wr_en),
        .i_addr_a (w_wr_addr),
        .i_dat_a  (i_vplex_in),
        .i_addr_b (w_rd_addr),
        .o_dat_b  (w_ram_q)
    );

    // Write side: bank flip and pointer clear per TV line, saturating advance per pixel.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wbank <= 1'b0;
            r_wptr  <= '0;
        end else if (i_tv_line_start) begin
            r_wbank <= ~r_wbank;
            r_wptr  <= '0;
        end else if (w_wr_en && (r_wptr != PTR_MAX)) begin
            r_wptr <= r_wptr + 1'b1;
        end
    end

    // Read side: latch the completed bank at each VGA line, saturating advance per read.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rbank <= 1'b1;
            r_rptr  <= '0;
        end else if (i_vga_line_start) begin
            r_rbank <= ~r_wbank;
            r_rptr  <= '0;
        end else if (w_rd_go && (r_rptr != PTR_MAX)) begin
            r_rptr <= r_rptr + 1'b1;
        end
    end

    // Output pipeline: load RAM data for real reads, zero for blanked reads, else hold.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_p1_rd    <= 1'b0;
            r_p1_blank <= 1'b0;
            r_vgaplex  <= 8'h00;
        end else begin
            r_p1_rd    <= w_rd_go;
            r_p1_blank <= w_rd_blank;
            if (r_p1_rd) begin
                r_vgaplex <= w_ram_q;
            end else if (r_p1_blank) begin
                r_vgaplex <= 8'h00;
            end
        end
    end

    // Odd/even VGA line flag; frame start wins over a coincident line start.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_vga_line <= 1'b0;
        end else if (i_frame_start) begin
            r_vga_line <= 1'b0;
        end else if (i_vga_line_start) begin
            r_vga_line <= ~r_vga_line;
        end
    end

    assign o_vgaplex  = r_vgaplex;
    assign o_vga_line = r_vga_line;

endmodule

// File: tb/tb_video_scandoubler.sv
// Bench for video_scandoubler: directed scenarios plus a randomized run.
// Latency: checks vgaplex 2 clk after each read strobe against a line-buffer model.
// Backpressure: n/a.
module tb_video_scandoubler;

    localparam int LEN = 512;
    localparam int HOLD = -1;  // no output update pending
    localparam int UNK  = -2;  // slot never written, content undefined

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       wr_stb = 1'b0;
    logic [7:0] vplex_in = 8'h00;
    logic       tv_active = 1'b0;
    logic       tv_line_start = 1'b0;
    logic       rd_stb = 1'b0;
    logic       vga_active = 1'b0;
    logic       vga_line_start = 1'b0;
    logic       frame_start = 1'b0;
    logic [7:0] vgaplex;
    logic       vga_line;

    int total = 0;
    int bad = 0;

    // Reference model: two line banks as plain arrays plus pointer/bank bookkeeping.
    int m_mem [2][LEN];
    int m_wbank, m_wptr, m_rbank, m_rptr, m_line, m_out, m_pend;

    video_scandoubler dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_wr_stb         (wr_stb),
        .i_vplex_in       (vplex_in),
        .i_tv_active      (tv_active),
        .i_tv_line_start  (tv_line_start),
        .i_rd_stb         (rd_stb),
        .i_vga_active     (vga_active),
        .i_vga_line_start (vga_line_start),
        .i_frame_start    (frame_start),
        .o_vgaplex        (vgaplex),
        .o_vga_line       (vga_line)
    );

    always #5 clk = ~clk;

    // Apply the behavioural rules for one clock edge using the current inputs.
    task automatic model_edge();
        if (!rst_n) begin
            m_wbank = 0; m_wptr = 0; m_rbank = 1; m_rptr = 0;
            m_line = 0; m_out = 0; m_pend = HOLD;
        end else begin
            if (m_pend != HOLD) m_out = m_pend;
            if (vga_line_start) begin
                m_rbank = 1 - m_wbank;
                m_rptr = 0;
                m_pend = HOLD;
            end else if (rd_stb && vga_active) begin
                m_pend = m_mem[m_rbank][m_rptr];
                if (m_rptr < LEN - 1) m_rptr++;
            end else if (rd_stb) begin
                m_pend = 0;
            end else begin
                m_pend = HOLD;
            end
            if (tv_line_start) begin
                m_wbank = 1 - m_wbank;
                m_wptr = 0;
            end else if (wr_stb && tv_active) begin
                m_mem[m_wbank][m_wptr] = int'(vplex_in);
                if (m_wptr < LEN - 1) m_wptr++;
            end
            if (frame_start) m_line = 0;
            else if (vga_line_start) m_line = 1 - m_line;
        end
    endtask

    task automatic tick(input logic ws, input logic [7:0] d, input logic ta, input logic tls,
                        input logic rs, input logic va, input logic vls, input logic fs);
        wr_stb = ws; vplex_in = d; tv_active = ta; tv_line_start = tls;
        rd_stb = rs; vga_active = va; vga_line_start = vls; frame_start = fs;
        @(posedge clk);
        model_edge();
        #1;
        wr_stb = 1'b0; tv_line_start = 1'b0; rd_stb = 1'b0;
        vga_line_start = 1'b0; frame_start = 1'b0;
    endtask

    task automatic idle();   tick(0, 8'h00, 1, 0, 0, 1, 0, 0); endtask
    task automatic tv_ls();  tick(0, 8'h00, 1, 1, 0, 1, 0, 0); endtask
    task automatic vga_ls(); tick(0, 8'h00, 1, 0, 0, 1, 1, 0); endtask
    task automatic wr(input logic [7:0] d); tick(1, d, 1, 0, 0, 1, 0, 0); endtask
    task automatic rd(input logic va);      tick(0, 8'h00, 1, 0, 1, va, 0, 0); endtask

    function automatic logic [7:0] sat_val(input int i);
        return 8'((i * 7 + 3) & 255);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
        total++;
        if (vgaplex !== 8'h00) begin bad++; $display("FAIL reset_vgaplex got=%h exp=00", vgaplex); end
        total++;
        if (vga_line !== 1'b0) begin bad++; $display("FAIL reset_vga_line got=%b exp=0", vga_line); end
    endtask

    task automatic test_basic_line();
        logic [7:0] exp;
        tv_ls();
        for (int i = 0; i < 8; i++) begin
            wr(8'(8'h10 + i));
            idle(); idle(); idle();
        end
        tv_ls();
        for (int l = 0; l < 2; l++) begin
            tick(0, 8'h00, 1, 0, 0, 1, 1, (l == 0));
            total++;
            if (vga_line !== 1'(l)) begin bad++; $display("FAIL basic_vga_line%0d got=%b exp=%0d", l, vga_line, l); end
            for (int i = 0; i < 8; i++) begin
                rd(1);
                idle();
                exp = 8'(8'h10 + i);
                total++;
                if (vgaplex !== exp) begin
                    bad++; $display("FAIL basic_px l%0d i%0d got=%h exp=%h", l, i, vgaplex, exp);
                end
            end
        end
    endtask

    task automatic test_saturate();
        logic [7:0] exp;
        tv_ls();
        for (int i = 0; i < 600; i++) wr(sat_val(i));
        tv_ls();
        vga_ls();
        for (int i = 0; i < LEN; i++) begin
            rd(1);
            if (i == 1) begin
                total++;
                if (vgaplex !== sat_val(0)) begin bad++; $display("FAIL sat_slot0 got=%h exp=%h", vgaplex, sat_val(0)); end
            end else if (i > 1) begin
                exp = m_out[7:0];
                total++;
                if (vgaplex !== exp) begin bad++; $display("FAIL sat_slot%0d got=%h exp=%h", i - 1, vgaplex, exp); end
            end
        end
        idle();
        total++;
        if (vgaplex !== sat_val(599)) begin bad++; $display("FAIL sat_slot511 got=%h exp=%h", vgaplex, sat_val(599)); end
    endtask

    task automatic test_drop_on_line_start();
        tick(1, 8'hAA, 1, 1, 0, 1, 0, 0);
        wr(8'h55);
        wr(8'h66);
        tv_ls();
        vga_ls();
        rd(1); idle();
        total++;
        if (vgaplex !== 8'h55) begin bad++; $display("FAIL drop_slot0 got=%h exp=55", vgaplex); end
        rd(1); idle();
        total++;
        if (vgaplex !== 8'h66) begin bad++; $display("FAIL drop_slot1 got=%h exp=66", vgaplex); end
    endtask

    task automatic test_blank_read();
        vga_ls();
        rd(0); idle();
        total++;
        if (vgaplex !== 8'h00) begin bad++; $display("FAIL blank_zero got=%h exp=00", vgaplex); end
        rd(1); idle();
        total++;
        if (vgaplex !== 8'h55) begin bad++; $display("FAIL blank_rptr_kept got=%h exp=55", vgaplex); end
    endtask

    task automatic test_frame_priority();
        tick(0, 8'h00, 1, 0, 0, 1, 0, 1);
        total++;
        if (vga_line !== 1'b0) begin bad++; $display("FAIL frame_clear got=%b exp=0", vga_line); end
        tick(0, 8'h00, 1, 0, 0, 1, 1, 1);
        total++;
        if (vga_line !== 1'b0) begin bad++; $display("FAIL frame_prio got=%b exp=0", vga_line); end
        vga_ls();
        total++;
        if (vga_line !== 1'b1) begin bad++; $display("FAIL frame_next_toggle got=%b exp=1", vga_line); end
    endtask

    task automatic test_reset_midline();
        logic [7:0] exp;
        // vga_line is 1 and vgaplex is 0x55 here, so the reset check is meaningful.
        tv_ls();
        for (int i = 0; i < 37; i++) wr(8'(8'hE0 + i));
        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
        total++;
        if (vgaplex !== 8'h00) begin bad++; $display("FAIL midrst_vgaplex got=%h exp=00", vgaplex); end
        total++;
        if (vga_line !== 1'b0) begin bad++; $display("FAIL midrst_vga_line got=%b exp=0", vga_line); end
        tv_ls();
        for (int i = 0; i < 4; i++) wr(8'(8'hC0 + i));
        tv_ls();
        vga_ls();
        for (int i = 0; i < 4; i++) begin
            rd(1); idle();
            exp = 8'(8'hC0 + i);
            total++;
            if (vgaplex !== exp) begin bad++; $display("FAIL midrst_px%0d got=%h exp=%h", i, vgaplex, exp); end
        end
    endtask

    task automatic test_random();
        logic [7:0] exp;
        for (int c = 0; c < 1500; c++) begin
            tick(($urandom_range(0, 3) == 0), 8'($urandom), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 59) == 0), ($urandom_range(0, 1) == 0),
                 ($urandom_range(0, 7) != 0), ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 149) == 0));
            if (m_out != UNK) begin
                exp = m_out[7:0];
                total++;
                if (vgaplex !== exp) begin bad++; $display("FAIL rand_vgaplex c%0d got=%h exp=%h", c, vgaplex, exp); end
            end
            total++;
            if (vga_line !== 1'(m_line)) begin bad++; $display("FAIL rand_vga_line c%0d got=%b exp=%0d", c, vga_line, m_line); end
        end
    endtask

    initial begin
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < LEN; a++) m_mem[b][a] = UNK;
        m_wbank = 0; m_wptr = 0; m_rbank = 1; m_rptr = 0;
        m_line = 0; m_out = 0; m_pend = HOLD;
        #2;
        test_reset();
        test_basic_line();
        test_saturate();
        test_drop_on_line_start();
        test_blank_read();
        test_frame_priority();
        test_reset_midline();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
